// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: access encodings, FSM states and alignment check for the data-memory arbiter
package rv_mem_pkg;
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, RD, RMW, ACK} state_t;

    // Undefined encodings report as misaligned so they never touch the RAM
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        return (op == OP_B || op == OP_BU) ? 1'b0 :
               (op == OP_H || op == OP_HU) ? a[0] :
               (op == OP_W)                ? (a != 2'b00) : 1'b1;
    endfunction
endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: load lane extraction with sign/zero extension and sub-word store merge
import rv_mem_pkg::*;

module dmem_lane (
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [2:0]  op,
    input  logic [1:0]  lane,
    output logic [31:0] ldata,
    output logic [31:0] mdata
);
    logic [31:0] sh, bm, bw;
    always_comb begin
        sh    = rdata >> {lane, 3'b000};
        ldata = op == OP_B  ? {{24{sh[7]}}, sh[7:0]} :
                op == OP_BU ? {24'b0, sh[7:0]} :
                op == OP_H  ? {{16{sh[15]}}, sh[15:0]} :
                op == OP_HU ? {16'b0, sh[15:0]} : rdata;
        // op[0] separates halfword from byte stores
        bm    = op[0] ? (32'h0000_FFFF << {lane[1], 4'b0000}) : (32'h0000_00FF << {lane, 3'b000});
        bw    = op[0] ? ({16'b0, wdata[15:0]} << {lane[1], 4'b0000}) : ({24'b0, wdata[7:0]} << {lane, 3'b000});
        mdata = (rdata & ~bm) | bw;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a single-port word RAM between CPU and debug ports
import rv_mem_pkg::*;

module dmem_arbiter #(
    parameter int AW = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [2:0]    c_op,
    input  logic [31:0]   c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_ready,
    output logic [31:0]   c_rdata,
    output logic          c_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ready,
    output logic [31:0]   d_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);
    state_t        state, state_n;
    logic          gnt_d, last_d, err_q;
    logic [2:0]    op_q;
    logic [AW-1:0] a_q;
    logic [1:0]    lane_q;
    logic [31:0]   wd_q, ldata, mdata;
    logic          any, pick_d, grant, sel_we, sel_err, busy;
    logic [2:0]    sel_op;
    logic [AW+1:0] sel_addr;
    logic [31:0]   sel_wd;
    logic          unused;

    assign unused = ^{c_addr[31:AW+2], d_addr[31:AW+2], d_addr[1:0]};

    always_comb begin
        any      = c_req | d_req;
        pick_d   = d_req & (~c_req | ~last_d);
        grant    = state == IDLE && any;
        sel_we   = pick_d ? d_we : c_we;
        sel_op   = pick_d ? OP_W : c_op;
        sel_addr = pick_d ? {d_addr[AW+1:2], 2'b00} : c_addr[AW+1:0];
        sel_wd   = pick_d ? d_wdata : c_wdata;
        sel_err  = ~pick_d & misaligned(c_op, c_addr[1:0]);
        state_n  = !grant ? IDLE : sel_err ? ACK : !sel_we ? RD : sel_op == OP_W ? ACK : RMW;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            last_d <= 1'b1;
            gnt_d  <= 1'b0;
            err_q  <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            lane_q <= '0;
            wd_q   <= '0;
        end else begin
            state <= state_n;
            if (grant) begin
                gnt_d  <= pick_d;
                last_d <= pick_d;
                err_q  <= sel_err;
                op_q   <= sel_op;
                a_q    <= sel_addr[AW+1:2];
                lane_q <= sel_addr[1:0];
                wd_q   <= sel_wd;
            end
        end
    end

    dmem_lane u_lane (
        .rdata(ram_rdata),
        .wdata(wd_q),
        .op   (op_q),
        .lane (lane_q),
        .ldata(ldata),
        .mdata(mdata)
    );

    // Reset gates every output so nothing reaches the RAM while reset is low
    always_comb begin
        busy      = state != IDLE;
        ram_en    = reset & (grant ? ~sel_err : state == RMW);
        ram_we    = reset & (grant ? ~sel_err & sel_we & (sel_op == OP_W) : state == RMW);
        ram_addr  = !reset ? '0 : grant ? sel_addr[AW+1:2] : a_q;
        ram_wdata = !reset ? '0 : state == RMW ? mdata : sel_wd;
        c_ready   = reset & busy & ~gnt_d;
        d_ready   = reset & busy & gnt_d;
        c_rdata   = (c_ready && state == RD) ? ldata : '0;
        d_rdata   = (d_ready && state == RD) ? ldata : '0;
        c_err     = c_ready & err_q;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus scoreboard check of the data-memory arbiter
import rv_mem_pkg::*;

module tb_dmem_arbiter;
    localparam int AW = 15;

    logic          clock = 0, reset = 0;
    logic          c_req = 0, c_we = 0, d_req = 0, d_we = 0;
    logic [2:0]    c_op = 0;
    logic [31:0]   c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
    logic          c_ready, c_err, d_ready, ram_en, ram_we;
    logic [31:0]   c_rdata, d_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [31:0]   mem [0:(1<<AW)-1];

    typedef struct { bit dbg; bit we; logic [2:0] op; logic [31:0] addr, wdata, rdata; bit err; } vec_t;
    typedef struct { bit dbg; logic [31:0] rdata; bit err; } exp_t;

    exp_t sb[$];
    vec_t tbl[19];
    int   passed = 0, total = 0, nready = 0;

    dmem_arbiter #(.AW(AW)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ready(c_ready), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    always @(negedge clock) begin
        if (reset && (c_ready || d_ready)) begin
            exp_t e;
            nready++;
            check("excl", {31'b0, c_ready & d_ready}, 0);
            if (sb.size() == 0) begin
                total++;
                $display("FAIL spurious: got ready with empty scoreboard expected none");
            end else begin
                e = sb.pop_front();
                check("port", {31'b0, d_ready}, {31'b0, e.dbg});
                check("rdata", d_ready ? d_rdata : c_rdata, e.rdata);
                check("err", {31'b0, c_err}, {31'b0, e.err});
            end
        end
    end

    task automatic access(input vec_t v);
        @(negedge clock);
        if (v.dbg) begin
            d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            c_req = 1; c_we = v.we; c_op = v.op; c_addr = v.addr; c_wdata = v.wdata;
        end
        sb.push_back('{v.dbg, v.rdata, v.err});
        #1 check("ram_en", {31'b0, ram_en}, {31'b0, !v.err});
        @(negedge clock);
        check("latency", {31'b0, v.dbg ? d_ready : c_ready}, 1);
        c_req = 0;
        d_req = 0;
    endtask

    initial begin
        int n;
        tbl[0]  = '{0, 1, OP_W,   32'h10,      32'h12345678, 32'h0,        0};
        tbl[1]  = '{0, 0, OP_W,   32'h10,      32'h0,        32'h12345678, 0};
        tbl[2]  = '{0, 1, OP_W,   32'h20,      32'h11223344, 32'h0,        0};
        tbl[3]  = '{0, 1, OP_B,   32'h21,      32'h123456AB, 32'h0,        0};
        tbl[4]  = '{0, 0, OP_W,   32'h20,      32'h0,        32'h1122AB44, 0};
        tbl[5]  = '{0, 0, OP_B,   32'h21,      32'h0,        32'hFFFFFFAB, 0};
        tbl[6]  = '{0, 0, OP_BU,  32'h21,      32'h0,        32'h000000AB, 0};
        tbl[7]  = '{0, 0, OP_H,   32'h22,      32'h0,        32'h00001122, 0};
        tbl[8]  = '{0, 0, OP_W,   32'h22,      32'h0,        32'h0,        1};
        tbl[9]  = '{0, 1, OP_H,   32'h23,      32'hBEEF,     32'h0,        1};
        tbl[10] = '{0, 0, OP_W,   32'h20,      32'h0,        32'h1122AB44, 0};
        tbl[11] = '{1, 1, OP_W,   32'h20004,   32'h5A5A5A5A, 32'h0,        0};
        tbl[12] = '{0, 0, OP_W,   32'h4,       32'h0,        32'h5A5A5A5A, 0};
        tbl[13] = '{1, 0, OP_W,   32'h13,      32'h0,        32'h12345678, 0};
        tbl[14] = '{0, 1, OP_H,   32'h22,      32'h9999CAFE, 32'h0,        0};
        tbl[15] = '{0, 0, OP_HU,  32'h22,      32'h0,        32'h0000CAFE, 0};
        tbl[16] = '{0, 0, OP_H,   32'h22,      32'h0,        32'hFFFFCAFE, 0};
        tbl[17] = '{0, 0, 3'b011, 32'h0,       32'h0,        32'h0,        1};
        tbl[18] = '{0, 0, OP_B,   32'h23,      32'h0,        32'hFFFFFFCA, 0};

        c_req = 1;
        c_we  = 1;
        #1;
        check("rst_ram_en", {31'b0, ram_en}, 0);
        check("rst_ram_we", {31'b0, ram_we}, 0);
        check("rst_state", {30'b0, dut.state}, {30'b0, IDLE});
        c_req = 0;
        repeat (3) @(negedge clock);
        reset = 1;

        for (int i = 0; i < 19; i++) access(tbl[i]);

        // Round-robin from reset with both ports held
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        c_we = 0; c_op = OP_W; c_addr = 32'h10;
        d_we = 0; d_addr = 32'h20;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{0, 32'h12345678, 0});
            sb.push_back('{1, 32'hCAFEAB44, 0});
        end
        n = nready;
        c_req = 1;
        d_req = 1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            if (nready - n >= 4) begin
                check("rr_cycles", k, 8);
                break;
            end
        end
        #1;
        c_req = 0;
        d_req = 0;
        check("rr_count", nready - n, 4);

        // Reset during the write half of a sub-word store
        @(negedge clock);
        c_req = 1; c_we = 1; c_op = OP_B; c_addr = 32'h20; c_wdata = 32'h77;
        @(posedge clock);
        #2 check("rmw_we", {31'b0, ram_we}, 1);
        reset = 0;
        #1;
        check("rmw_rst_we", {31'b0, ram_we}, 0);
        check("rmw_rst_rdy", {31'b0, c_ready}, 0);
        check("rmw_rst_state", {30'b0, dut.state}, {30'b0, IDLE});
        c_req = 0;
        @(negedge clock);
        reset = 1;
        access('{0, 0, OP_W, 32'h20, 32'h0, 32'hCAFEAB44, 0});

        repeat (2) @(negedge clock);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares one single-port, word-organised data RAM between the RV32I core's data port and a debug/loader port. Arbitrates round-robin, performs byte/halfword extraction on loads, read-modify-write on sub-word stores, and flags misaligned accesses. Sits between `rv32is` (plus the debug loader) and the data RAM, replacing the core's direct `dmem*` wiring. Every access uses a req/ready handshake, so the core must stall on `c_ready`.

## Interface
- `AW`, default 15: RAM word-address width. The RAM holds 2^AW words, so byte-address bits [AW+1:2] are used and upper bits are ignored (wrap).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  CPU request. Held with its fields until `c_ready`.
- `c_we`  in  1  CPU store (1) or load (0).
- `c_op`  in  3  CPU access type, RV32 funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `c_addr`  in  32  CPU byte address.
- `c_wdata`  in  32  CPU store data, right-aligned.
- `c_ready`  out  1  one-cycle completion pulse.
- `c_rdata`  out  32  load result, extended per `c_op`. Valid only while `c_ready`, otherwise 0.
- `c_err`  out  1  misalignment flag, valid with `c_ready`.
- `d_req`, `d_we`, `d_addr[31:0]`, `d_wdata[31:0]`  in: debug port. Word access only, `d_addr[1:0]` ignored.
- `d_ready`  out  1 and `d_rdata`  out  32: same rules as the CPU port.
- `ram_en`  out  1  RAM access enable.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  AW  word address.
- `ram_wdata`  out  32  full write word.
- `ram_rdata`  in  32  RAM read data, valid one cycle after `ram_en` with `ram_we`=0.

## Operation
- FSM states are IDLE, RD, RMW and ACK.
- **IDLE:** sample requests and pick a grant.
  - If only one requester is active, it wins.
  - If both are active, the requester not granted last wins. The last-grant pointer resets to "debug", so CPU wins first.
- **Load:** issue `ram_en`=1 in IDLE, then go to RD. In RD, extract the lane selected by `c_addr[1:0]`, sign- or zero-extend it, and assert ready.
- **Word store:** issue `ram_en`=`ram_we`=1 with `c_wdata` in IDLE, then go to ACK. ACK asserts ready.
- **Sub-word store (sb/sh):** issue a read in IDLE, then go to RMW. In RMW, merge the low byte/half of `c_wdata` into `ram_rdata` at the addressed lane, write it with `ram_en`=`ram_we`=1, and assert ready.
- Every state other than IDLE returns to IDLE after one cycle. The granted request is latched in IDLE, so later changes on the requester's inputs are ignored.
- **Misaligned access:** lh/lhu/sh with `addr[0]`=1, or lw/sw with `addr[1:0]`≠0.
  - No RAM access is made, and the FSM goes to ACK.
  - `c_ready`=1, `c_err`=1, `c_rdata`=0.
  - RAM contents are unchanged.
- **Undefined `c_op`** (011, 110, 111): treat as misaligned (err).
- **Reset low:** state becomes IDLE, all outputs go to 0 immediately (the `ram_en`/`ram_we` gating is combinational), and the pointer is set to debug. Resetting in the middle of an RMW leaves the word unwritten.

## Timing
- Cycle 0 is the IDLE cycle in which a request is granted. `*_ready` is asserted in cycle 1 for every access type, so latency is 1 cycle.
- The next grant can happen in cycle 2, giving a peak throughput of one access per 2 cycles.
- A requester must drop or change `req` in the cycle after `ready`. A `req` still high in cycle 2 is treated as a new request.
- Only one of `c_ready` and `d_ready` is high in any cycle.
- `ram_*` outputs and `*_ready`/`*_rdata`/`*_err` are combinational from the state and latched fields. The latched fields and the pointer are registered.

## Structure
- Package `rv_mem_pkg` holds:
  - the `c_op` encodings (`OP_B`, `OP_H`, `OP_W`, `OP_BU`, `OP_HU`);
  - the FSM state enum;
  - a misalignment check function.
- Sub-module `dmem_lane` (combinational) handles load lane extraction with extension and store lane merge. The top level contains the FSM, arbiter and latches.

## Test plan
- **Word round trip:** CPU `sw` 0x12345678 to 0x10, then `lw` 0x10 → `c_ready` in cycle 1 of each, `c_rdata`=0x12345678, `c_err`=0.
- **Sub-word store and loads:** `sw` 0x11223344 to 0x20, then `sb` 0xAB to 0x21. Then:
  - `lw` 0x20 → 0x1122AB44;
  - `lb` 0x21 → 0xFFFFFFAB;
  - `lbu` 0x21 → 0x000000AB;
  - `lh` 0x22 → 0x00001122.
- **Round-robin:** CPU and debug request together from reset and hold.
  - Grants go CPU, debug, CPU, debug.
  - `c_ready` and `d_ready` are never high together.
- **Misalignment:** `lw` 0x22 and `sh` 0x23 → ready in cycle 1 with err=1 and rdata=0. `ram_en` stays 0 and the RAM word is unchanged.
- **Reset mid-RMW:** pull `reset` low during the RMW cycle of an `sb` → `ram_we` drops immediately, the FSM is in IDLE after reset, and the word keeps its old value.
- **Wrap:** with AW=15, debug writes 0x5A5A5A5A to 0x0002_0004 → CPU `lw` 0x4 returns 0x5A5A5A5A.
